// File: rtl/sram_access_controller.sv
// sram_access_controller: sequences one 32-bit data-memory access as two
// 16-bit SRAM phases (LO half-word, then HI half-word), each stretched by
// WAIT_CYCLES extra cycles. Only one access is outstanding at a time.
// `ready` drops while an access is in flight, which freezes the pipeline.
// Optional feature macro: SRAM_CTRL_WRITE_BUFFER_EN. When it is defined,
// stores are acknowledged in their request cycle and the SRAM write runs
// in the background.
module sram_access_controller #(
  parameter logic [31:0] DATA_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [16:0] word_idx;    // latched offset[18:2]
  logic [15:0] wdata_hi;    // upper store half, driven during HI
  logic        op_wr;       // latched operation type

  logic        req;
  logic        accept;
  logic        phase_end;
  logic [31:0] offset_full;
  logic        unused_offset_bits;

  assign req         = wr_en | rd_en;
  assign accept      = (state == IDLE) && req;
  assign phase_end   = (wait_cnt == LAST_WAIT);
  assign offset_full = address - DATA_BASE;
  // The byte lane and the bits above the 2^19-byte window are dropped.
  assign unused_offset_bits = ^{offset_full[31:19], offset_full[1:0]};

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and ready decode.
  // NOTE: outputs get a default before the case so no path leaves them
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = LO;
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
        // A store is acknowledged in its own request cycle.
        ready = ~req | wr_en;
`else
        ready = ~req;
`endif
      end
      LO: begin
        if (phase_end) state_next = HI;
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
        // A background store does not stall an idle pipeline.
        ready = op_wr & ~req;
`endif
      end
      HI: begin
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
        if (phase_end) state_next = op_wr ? IDLE : DONE;
        ready = op_wr & ~req;
`else
        if (phase_end) state_next = DONE;
`endif
      end
      DONE: begin
        // Always return to IDLE so a still-held request cannot restart.
        state_next = IDLE;
        ready      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // The pipeline is released while the controller is held in reset.
    if (rst) ready = 1'b1;
  end

  // Per-phase wait counter; restarts from zero on every phase entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wait_cnt <= '0;
    else if (state_next != state)     wait_cnt <= '0;
    else if (state == LO || state == HI) wait_cnt <= wait_cnt + 4'd1;
  end

  // Request latch: address, upper store half and operation type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
      wdata_hi <= '0;
      op_wr    <= 1'b0;
    end else if (accept) begin
      word_idx <= offset_full[18:2];
      wdata_hi <= write_data[31:16];
      op_wr    <= wr_en;
    end
  end

  // Registered SRAM pins; they only move on phase entry or exit edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else if (accept) begin
      sram_addr   <= {offset_full[18:2], 1'b0};
      sram_dq_out <= write_data[15:0];
      sram_dq_oe  <= wr_en;
      sram_we_n   <= ~wr_en;
    end else if (state == LO && phase_end) begin
      sram_addr   <= {word_idx, 1'b1};
      sram_dq_out <= wdata_hi;
    end else if (state == HI && phase_end) begin
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end
  end

  // Load capture: low half on the edge ending LO, high half ending HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!op_wr && phase_end) begin
      if (state == LO) read_data[15:0]  <= sram_dq_in;
      if (state == HI) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Testbench for sram_access_controller: directed literal cases plus
// randomized load/store traffic checked every cycle against a
// transaction-level model (cycle index within the access, shadow memory).
// Build with SRAM_CTRL_WRITE_BUFFER_EN defined to exercise buffered stores.
module tb_sram_access_controller;

  localparam int unsigned BASE = 1024;
  localparam int          W    = 1;
  localparam int          MEMW = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sram_access_controller #(.DATA_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten SRAM locations read back a fixed pattern of their address.
  function automatic logic [15:0] fill(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // External SRAM model.
  logic [15:0] sram_mem [0:MEMW-1];
  bit          sram_vld [0:MEMW-1];
  assign sram_dq_in = sram_vld[sram_addr] ? sram_mem[sram_addr] : fill(sram_addr);

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      sram_mem[sram_addr] <= sram_dq_out;
      sram_vld[sram_addr] <= 1'b1;
    end
  end

  // Reference model: k is the index of the current cycle within the access
  // (0 = idle), shadow holds the memory contents the stores imply.
  logic [15:0] shadow     [0:MEMW-1];
  bit          shadow_vld [0:MEMW-1];
  int          k = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_off = '0, m_wd = '0, m_word = '0, m_rd = '0;
  wire  [31:0] in_off = address - BASE;

  function automatic logic [15:0] shadow_rd(input logic [17:0] a);
    return shadow_vld[a] ? shadow[a] : fill(a);
  endfunction

  function automatic int end_k(input bit wr);
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
    return wr ? 2*W+2 : 2*W+3;
`else
    return 2*W+3;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k    <= 0;
      m_rd <= '0;
    end else if (k == 0) begin
      if (wr_en || rd_en) begin
        k     <= 1;
        m_wr  <= wr_en;
        m_off <= in_off;
        m_wd  <= write_data;
        if (wr_en) begin
          shadow[{in_off[18:2], 1'b0}]     <= write_data[15:0];
          shadow[{in_off[18:2], 1'b1}]     <= write_data[31:16];
          shadow_vld[{in_off[18:2], 1'b0}] <= 1'b1;
          shadow_vld[{in_off[18:2], 1'b1}] <= 1'b1;
        end else begin
          m_word <= {shadow_rd({in_off[18:2], 1'b1}), shadow_rd({in_off[18:2], 1'b0})};
        end
      end
    end else begin
      if (!m_wr && k == W+1)   m_rd[15:0]  <= m_word[15:0];
      if (!m_wr && k == 2*W+2) m_rd[31:16] <= m_word[31:16];
      k <= (k == end_k(m_wr)) ? 0 : k + 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit lo, hi, done, req, exp_ready;
    if (chk_en) begin
      req  = wr_en | rd_en;
      lo   = (k >= 1) && (k <= W+1);
      hi   = (k >= W+2) && (k <= 2*W+2);
      done = (k == 2*W+3);
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
      exp_ready = rst || (k == 0 && (!req || wr_en)) || done || ((lo || hi) && m_wr && !req);
`else
      exp_ready = rst || (k == 0 && !req) || done;
`endif
      check("ready", 32'(ready), 32'(exp_ready));
      check("read_data", read_data, m_rd);
      check("we_n", 32'(sram_we_n), 32'(!(m_wr && (lo || hi))));
      check("dq_oe", 32'(sram_dq_oe), 32'(m_wr && (lo || hi)));
      if (lo || hi)
        check("sram_addr", 32'(sram_addr), 32'({m_off[18:2], hi}));
      if (m_wr && (lo || hi))
        check("dq_out", 32'(sram_dq_out), 32'(hi ? m_wd[31:16] : m_wd[15:0]));
      if (rst) begin
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until ready is seen; lat counts the frozen cycles.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input bit abandon, output int lat);
    wr_en = wr; rd_en = rd; address = a; write_data = d; lat = 0;
    if (abandon) begin
      next_cycle();
      wr_en = 1'b0; rd_en = 1'b0;
      repeat (2*W+5) next_cycle();
      return;
    end
    forever begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (lat > 64) begin
        checks++; errors++;
        $display("FAIL timeout: ready not seen after %0d cycles", lat);
        break;
      end
    end
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_read_data", read_data, 32'd0);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_oe", 32'(sram_dq_oe), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Store 0xDEADBEEF at byte 1024 (SRAM word 0).
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024; write_data = 32'hDEADBEEF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        check("w_addr_lo", 32'(sram_addr), 32'd0);
        check("w_dq_lo", 32'(sram_dq_out), 32'h0000BEEF);
        check("w_we_lo", 32'(sram_we_n), 32'd0);
      end
      if (c == 3 || c == 4) begin
        check("w_addr_hi", 32'(sram_addr), 32'd1);
        check("w_dq_hi", 32'(sram_dq_out), 32'h0000DEAD);
        check("w_we_hi", 32'(sram_we_n), 32'd0);
      end
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
      if (c == 0) check("w_ready_c0", 32'(ready), 32'd1);
`else
      if (c == 4) check("w_ready_c4", 32'(ready), 32'd0);
`endif
      if (c == 5) check("w_ready_c5", 32'(ready), 32'd1);
      next_cycle();
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
      if (c == 0) wr_en = 1'b0;
`endif
    end
    wr_en = 1'b0;

    // Read it back.
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check("r_we_n", 32'(sram_we_n), 32'd1);
      if (c == 4) check("r_ready_c4", 32'(ready), 32'd0);
      if (c == 5) begin
        check("r_ready_c5", 32'(ready), 32'd1);
        check("r_data_c5", read_data, 32'hDEADBEEF);
      end
      next_cycle();
    end
    rd_en = 1'b0;
    next_cycle();

    // Both enables: the store wins, read_data is untouched.
    do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, lat);
`ifndef SRAM_CTRL_WRITE_BUFFER_EN
    check("both_latency", 32'(lat), 32'd5);
`endif
    repeat (2*W+3) next_cycle();
    check("both_keeps_rd", read_data, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, lat);
    check("both_readback", read_data, 32'h12345678);
    check("read_latency", 32'(lat), 32'd5);

    // Reset in cycle 2 of a read, request still held across release.
    rd_en = 1'b1; address = 32'd1040;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_oe", 32'(sram_dq_oe), 32'd0);
    check("midrst_rd", read_data, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("post_rst_addr", 32'(sram_addr), 32'd8);
    do_access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, lat);
    check("post_rst_data", read_data, 32'h5A355A34);

`ifdef SRAM_CTRL_WRITE_BUFFER_EN
    // Buffered store followed immediately by a load of the same word.
    do_access(1'b1, 1'b0, 32'd1064, 32'hA5C3_1E0F, 1'b0, lat);
    check("wb_write_lat", 32'(lat), 32'd0);
    do_access(1'b0, 1'b1, 32'd1064, 32'h0, 1'b0, lat);
    check("wb_read_lat", 32'(lat), 32'd9);
    check("wb_read_data", read_data, 32'hA5C3_1E0F);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h80000 * $urandom_range(1, 7);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      do_access(op < 4 || op == 9, op >= 4, a, $urandom,
                $urandom_range(0, 15) == 0, lat);
      repeat ($urandom_range(0, 2)) next_cycle();
    end
    repeat (2*W+5) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
